// File: rtl/alu_uart_host_if.sv
// FIFO-side bundle for the ALU UART host.
// The master pushes operands to TX and pops responses from RX.
interface alu_uart_host_if #(
  parameter int NB_DATA = 8
);
  logic               i_fifo_tx_full;
  logic               o_fifo_tx_write;
  logic [NB_DATA-1:0] o_data_to_write;
  logic               i_fifo_rx_empty;
  logic               o_fifo_rx_read;
  logic [NB_DATA-1:0] i_data_to_read;

  modport master (
    input  i_fifo_tx_full,
    output o_fifo_tx_write,
    output o_data_to_write,
    input  i_fifo_rx_empty,
    output o_fifo_rx_read,
    input  i_data_to_read
  );

  modport slave (
    output i_fifo_tx_full,
    input  o_fifo_tx_write,
    input  o_data_to_write,
    output i_fifo_rx_empty,
    input  o_fifo_rx_read,
    output i_data_to_read
  );
endinterface

// File: rtl/alu_uart_host.sv
// ALU UART host: sends opcode, A, B over the TX FIFO
// and waits (with timeout) for one result byte on RX.
module alu_uart_host #(
  parameter int NB_DATA    = 8,
  parameter int NB_OPCODE  = 6,
  parameter int NB_TIMEOUT = 16,
  parameter int TIMEOUT    = 50000
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic [NB_DATA-1:0]   i_op_a,
  input  logic [NB_DATA-1:0]   i_op_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [NB_DATA-1:0]   o_result,
  alu_uart_host_if.master      fifo
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_OP,
    SEND_A,
    SEND_B,
    WAIT_RESP,
    DONE
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] TMO_LAST =
    NB_TIMEOUT'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [NB_DATA-1:0]    op_q, op_d;
  logic [NB_DATA-1:0]    a_q, a_d;
  logic [NB_DATA-1:0]    b_q, b_d;
  logic [NB_DATA-1:0]    res_q, res_d;
  logic [NB_TIMEOUT-1:0] tmo_q, tmo_d;
  logic                  done_q, done_d;
  logic                  tmo_ev_q, tmo_ev_d;
  logic                  tx_wr, rx_rd;
  logic [NB_DATA-1:0]    wdata;

  // Next state, operand latching, timeout count and FIFO strobes
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    tmo_d    = tmo_q;
    tmo_ev_d = 1'b0;
    tx_wr    = 1'b0;
    rx_rd    = 1'b0;
    wdata    = '0;
    unique case (state_q)
      IDLE: begin
        rx_rd = ~fifo.i_fifo_rx_empty;
        if (i_start) begin
          op_d    = NB_DATA'(i_opcode);
          a_d     = i_op_a;
          b_d     = i_op_b;
          state_d = SEND_OP;
        end
      end
      SEND_OP: begin
        tx_wr = ~fifo.i_fifo_tx_full;
        wdata = op_q;
        if (tx_wr) state_d = SEND_A;
      end
      SEND_A: begin
        tx_wr = ~fifo.i_fifo_tx_full;
        wdata = a_q;
        if (tx_wr) state_d = SEND_B;
      end
      SEND_B: begin
        tx_wr = ~fifo.i_fifo_tx_full;
        wdata = b_q;
        if (tx_wr) begin
          state_d = WAIT_RESP;
          tmo_d   = '0;
        end
      end
      WAIT_RESP: begin
        rx_rd = ~fifo.i_fifo_rx_empty;
        if (rx_rd) begin
          res_d   = fifo.i_data_to_read;
          state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_ev_d = 1'b1;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + NB_TIMEOUT'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      tmo_ev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      tmo_ev_q <= tmo_ev_d;
    end
  end

  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;
  assign o_timeout = tmo_ev_q;
  assign o_result  = res_q;

  // Strobes are gated by reset so they drop with no clock edge
  assign fifo.o_fifo_tx_write = tx_wr & i_reset_n;
  assign fifo.o_fifo_rx_read  = rx_rd & i_reset_n;
  assign fifo.o_data_to_write = wdata;

endmodule

// File: tb/tb_alu_uart_host.sv
// Directed bench for alu_uart_host with
// behavioural TX/RX FIFO models.
module tb_alu_uart_host;

  localparam int NB_DATA   = 8;
  localparam int NB_OPCODE = 6;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [NB_OPCODE-1:0] opcode;
  logic [NB_DATA-1:0]   op_a;
  logic [NB_DATA-1:0]   op_b;
  logic                 busy;
  logic                 done;
  logic                 tmo;
  logic [NB_DATA-1:0]   result;

  alu_uart_host_if #(.NB_DATA(NB_DATA)) fif ();

  alu_uart_host #(
    .NB_DATA   (NB_DATA),
    .NB_OPCODE (NB_OPCODE),
    .NB_TIMEOUT(16),
    .TIMEOUT   (10)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_start  (start),
    .i_opcode (opcode),
    .i_op_a   (op_a),
    .i_op_b   (op_b),
    .o_busy   (busy),
    .o_done   (done),
    .o_timeout(tmo),
    .o_result (result),
    .fifo     (fif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx_mem [16];
  int         rx_wr;
  int         rx_rd;
  logic [7:0] tx_log [64];
  int         tx_n;
  logic       tx_full;

  assign fif.i_fifo_tx_full  = tx_full;
  assign fif.i_fifo_rx_empty = (rx_rd == rx_wr);
  assign fif.i_data_to_read  = rx_mem[rx_rd % 16];

  // FIFO models: record pushes, advance RX head on pops
  always @(posedge clk) begin
    if (fif.o_fifo_tx_write) begin
      tx_log[tx_n % 64] <= fif.o_data_to_write;
      tx_n <= tx_n + 1;
    end
    if (fif.o_fifo_rx_read) rx_rd <= rx_rd + 1;
  end

  int n_chk;
  int n_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_mem[rx_wr % 16] = b;
    rx_wr = rx_wr + 1;
  endtask

  // Pulse start for one edge; returns 1 ns after that edge
  task automatic go(input logic [5:0] o,
                    input logic [7:0] a,
                    input logic [7:0] b);
    opcode = o;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    cyc();
    start  = 1'b0;
  endtask

  int base;

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rx_wr   = 0;
    rx_rd   = 0;
    tx_n    = 0;
    tx_full = 1'b0;
    start   = 1'b0;
    opcode  = '0;
    op_a    = '0;
    op_b    = '0;
    rst_n   = 1'b0;
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_result", result, 0);
    chk("rst_txw", fif.o_fifo_tx_write, 0);
    chk("rst_rxr", fif.o_fifo_rx_read, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Nominal transaction, response arrives for edge 6
    base = tx_n;
    go(6'h20, 8'h05, 8'h03);
    chk("nom_busy", busy, 1);
    cyc(3);
    chk("nom_txn", tx_n - base, 3);
    chk("nom_tx0", tx_log[base], 8'h20);
    chk("nom_tx1", tx_log[base+1], 8'h05);
    chk("nom_tx2", tx_log[base+2], 8'h03);
    chk("nom_txw_wait", fif.o_fifo_tx_write, 0);
    cyc(2);
    chk("nom_nodone", done, 0);
    rx_push(8'h08);
    cyc();
    chk("nom_done", done, 1);
    chk("nom_result", result, 8'h08);
    chk("nom_tmo", tmo, 0);
    cyc();
    chk("nom_done_clr", done, 0);
    chk("nom_idle", busy, 0);

    // Timeout: no response, pulse 10 cycles after WAIT_RESP entry
    base = tx_n;
    go(6'h01, 8'h02, 8'h03);
    cyc(3);
    chk("to_txn", tx_n - base, 3);
    cyc(9);
    chk("to_early", tmo, 0);
    chk("to_busy", busy, 1);
    cyc();
    chk("to_pulse", tmo, 1);
    chk("to_nodone", done, 0);
    chk("to_result", result, 8'h08);
    chk("to_idle", busy, 0);
    cyc();
    chk("to_once", tmo, 0);

    // Race: response in the final timeout cycle wins
    go(6'h02, 8'h00, 8'h00);
    cyc(3);
    cyc(9);
    rx_push(8'h11);
    cyc();
    chk("race_done", done, 1);
    chk("race_tmo", tmo, 0);
    chk("race_result", result, 8'h11);
    cyc();
    chk("race_tmo2", tmo, 0);
    chk("race_idle", busy, 0);

    // Backpressure during SEND_A for 5 cycles
    base = tx_n;
    go(6'h21, 8'h44, 8'h55);
    cyc();
    tx_full = 1'b1;
    #1;
    chk("bp_txw_full", fif.o_fifo_tx_write, 0);
    cyc(5);
    chk("bp_held", tx_n - base, 1);
    tx_full = 1'b0;
    #1;
    chk("bp_txw", fif.o_fifo_tx_write, 1);
    chk("bp_data", fif.o_data_to_write, 8'h44);
    cyc(2);
    chk("bp_txn", tx_n - base, 3);
    chk("bp_tx0", tx_log[base], 8'h21);
    chk("bp_tx1", tx_log[base+1], 8'h44);
    chk("bp_tx2", tx_log[base+2], 8'h55);
    rx_push(8'h99);
    cyc();
    chk("bp_done", done, 1);
    chk("bp_result", result, 8'h99);
    cyc();

    // Stale drain while idle
    rx_push(8'hAA);
    rx_push(8'hBB);
    #1;
    chk("drain_rd", fif.o_fifo_rx_read, 1);
    cyc(2);
    chk("drain_empty", rx_wr - rx_rd, 0);
    chk("drain_result", result, 8'h99);
    chk("drain_busy", busy, 0);
    chk("drain_nodone", done, 0);

    // Second start during WAIT_RESP is ignored
    base = tx_n;
    go(6'h03, 8'h04, 8'h05);
    cyc(3);
    go(6'h3F, 8'hEE, 8'hDD);
    cyc(3);
    chk("ign_txn", tx_n - base, 3);
    chk("ign_busy", busy, 1);
    rx_push(8'h77);
    cyc();
    chk("ign_done", done, 1);
    chk("ign_result", result, 8'h77);
    cyc();
    chk("ign_idle", busy, 0);
    chk("ign_txn2", tx_n - base, 3);

    // Async reset in SEND_B with no clock edge
    base = tx_n;
    go(6'h06, 8'h07, 8'h08);
    cyc(2);
    chk("ar_txw_pre", fif.o_fifo_tx_write, 1);
    chk("ar_data_pre", fif.o_data_to_write, 8'h08);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_txw", fif.o_fifo_tx_write, 0);
    chk("ar_rxr", fif.o_fifo_rx_read, 0);
    chk("ar_result", result, 0);
    chk("ar_done", done, 0);
    chk("ar_tmo", tmo, 0);
    chk("ar_data", fif.o_data_to_write, 0);
    cyc(2);
    chk("ar_txn", tx_n - base, 2);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    base = tx_n;
    go(6'h0A, 8'h0B, 8'h0C);
    cyc(3);
    chk("post_txn", tx_n - base, 3);
    chk("post_tx0", tx_log[base], 8'h0A);
    chk("post_tx1", tx_log[base+1], 8'h0B);
    chk("post_tx2", tx_log[base+2], 8'h0C);
    rx_push(8'h0D);
    cyc();
    chk("post_done", done, 1);
    chk("post_result", result, 8'h0D);
    cyc();
    chk("post_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
